div_sequencer: RTL



---
 rtl/div_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            BUSY,
  output logic            RESULT_VALID,
  output logic [XLEN-1:0] RESULT
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, result_q, result_d;
  logic            rem_flag_q, rem_flag_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic            accept, sgn, d1_neg, d2_neg, div_zero, ovf;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] q_fix, r_fix;
  always_comb begin
    accept   = (state_q == IDLE) & START & FUNCT3[2] & ~FLUSH;
    sgn      = ~FUNCT3[0];
    d1_neg   = sgn & DATA1[XLEN-1];
    d2_neg   = sgn & DATA2[XLEN-1];
    div_zero = (DATA2 == '0);
    ovf      = sgn & (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) & (DATA2 == '1);
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    q_fix    = neg_q_q ? -quo_q : quo_q;
    r_fix    = neg_r_q ? -rem_q : rem_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    result_d   = result_q;
    rem_flag_d = rem_flag_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    unique case (state_q)
      IDLE: if (accept) begin
        rem_flag_d = FUNCT3[1];
        neg_q_d    = d1_neg ^ d2_neg;
        neg_r_d    = d1_neg;
        if (div_zero | ovf) begin
          // Special cases bypass the iteration and write the architectural result directly
          result_d = FUNCT3[1] ? (div_zero ? DATA1 : '0) : (div_zero ? '1 : DATA1);
          state_d  = DONE;
        end else begin
          quo_d   = d1_neg ? -DATA1 : DATA1;
          dvs_d   = d2_neg ? -DATA2 : DATA2;
          rem_d   = '0;
          cnt_d   = CW'(XLEN - 1);
          state_d = CALC;
        end
      end
      CALC: if (FLUSH) state_d = IDLE;
      else begin
        rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? FIX : CALC;
      end
      FIX: if (FLUSH) state_d = IDLE;
      else begin
        result_d = rem_flag_q ? r_fix : q_fix;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      result_q   <= '0;
      rem_flag_q <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      result_q   <= result_d;
      rem_flag_q <= rem_flag_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
    end
  end
  assign STALL        = accept | (state_q == CALC) | (state_q == FIX);
  assign BUSY         = (state_q != IDLE);
  assign RESULT_VALID = (state_q == DONE);
  assign RESULT       = result_q;
endmodule
